// File: rtl/sample_player_pkg.sv
// Shared types and default constants for the sample player.
//   state_t      : playback FSM states
//   DEFAULT_DIV  : clocks per output sample
//   DEFAULT_FRAC : fractional bits in step/phase
package sample_player_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PLAY  = 2'd1,
      FETCH = 2'd2
   } state_t;

   localparam int unsigned DEFAULT_DIV  = 1042;
   localparam int unsigned DEFAULT_FRAC = 8;

endpackage

// File: rtl/sample_tick.sv
// Free-running output-rate divider: tick is a registered one-cycle pulse
// every DIV clocks, starting DIV clocks after reset release.
//   clk  : clock
//   rst  : synchronous active-high reset
//   tick : one-cycle pulse every DIV clocks
module sample_tick
   import sample_player_pkg::*;
#(
   parameter int unsigned DIV = DEFAULT_DIV
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

   logic [CW-1:0] cnt;

   // Count 0..DIV-1; tick registers the terminal count
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt  <= '0;
         tick <= 1'b0;
      end else if (cnt == CW'(DIV - 1)) begin
         cnt  <= '0;
         tick <= 1'b1;
      end else begin
         cnt  <= cnt + CW'(1);
         tick <= 1'b0;
      end
   end

endmodule

// File: rtl/sample_player.sv
// Plays samples from an external registered ROM at a fixed output rate with a
// fractional phase step, volume scaling, optional looping and stop/restart.
//   clk, rst     : clock, synchronous active-high reset
//   start, stop  : play / halt pulses (stop wins)
//   loop         : wrap at end of ROM instead of finishing
//   step         : unsigned fixed-point phase increment (FRAC fractional bits)
//   volume       : unsigned gain, 255 ~ unity
//   rom_addr     : ROM address (integer part of phase)
//   rom_data     : ROM data, one cycle after rom_addr
//   sample       : scaled signed sample, updated every output tick
//   sample_valid : one-cycle pulse two cycles after each tick
//   busy, done   : playing / end-of-sample pulse (with its sample_valid)
`ifndef SAMPLES_LENGTH
`define SAMPLES_LENGTH 1024
`endif

module sample_player
   import sample_player_pkg::*;
#(
   parameter int unsigned LENGTH = `SAMPLES_LENGTH,
   parameter int unsigned WIDTH  = 20,
   parameter int unsigned ADDR   = $clog2(LENGTH),
   parameter int unsigned DIV    = DEFAULT_DIV,
   parameter int unsigned FRAC   = DEFAULT_FRAC
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic                    stop,
   input  logic                    loop,
   input  logic [ADDR+FRAC-1:0]    step,
   input  logic [7:0]              volume,
   output logic [ADDR-1:0]         rom_addr,
   input  logic signed [WIDTH-1:0] rom_data,
   output logic signed [WIDTH-1:0] sample,
   output logic                    sample_valid,
   output logic                    busy,
   output logic                    done
);

   localparam int unsigned PW    = ADDR + FRAC;
   localparam int unsigned PS    = PW + 1;
   localparam int unsigned PRODW = WIDTH + 9;
   localparam logic [PS-1:0] LIMIT = PS'(LENGTH) << FRAC;

   state_t                   state;
   logic [PW-1:0]            phase;
   logic [PW-1:0]            step_q;
   logic                     loop_q;
   logic                     tick;
   logic                     tick_d;

   logic [PS-1:0]            sum_c;
   logic [PS-1:0]            wrap_c;
   logic                     at_end_c;
   logic signed [PRODW-1:0]  prod_c;
   logic signed [WIDTH-1:0]  scaled_c;

   sample_tick #(.DIV(DIV)) u_tick (
      .clk  (clk),
      .rst  (rst),
      .tick (tick)
   );

   assign rom_addr = phase[PW-1:FRAC];

   // Next phase candidates and volume scaling (volume treated as unsigned)
   always_comb begin
      sum_c    = {1'b0, phase} + {1'b0, step_q};
      wrap_c   = sum_c - LIMIT;
      at_end_c = (sum_c >= LIMIT);
      prod_c   = rom_data * $signed({1'b0, volume});
      scaled_c = WIDTH'(prod_c >>> 8);
   end

   // Playback FSM; sample is zeroed on every tick unless a FETCH captures it
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         phase        <= '0;
         step_q       <= '0;
         loop_q       <= 1'b0;
         tick_d       <= 1'b0;
         sample       <= '0;
         sample_valid <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
      end else begin
         tick_d       <= tick;
         sample_valid <= tick_d;
         done         <= 1'b0;
         if (tick_d) begin
            sample <= '0;
         end

         if (stop) begin
            state <= IDLE;
            busy  <= 1'b0;
         end else if (start) begin
            // Restart; a capture already in progress still delivers its sample
            phase  <= '0;
            step_q <= step;
            loop_q <= loop;
            state  <= PLAY;
            busy   <= 1'b1;
            if (state == FETCH) begin
               sample <= scaled_c;
            end
         end else begin
            case (state)
               IDLE: begin
               end
               PLAY: begin
                  if (tick) begin
                     state <= FETCH;
                  end
               end
               FETCH: begin
                  sample <= scaled_c;
                  state  <= PLAY;
                  if (!at_end_c) begin
                     phase <= sum_c[PW-1:0];
                  end else if (loop_q) begin
                     // Huge steps can overshoot even after one wrap
                     phase <= (wrap_c >= LIMIT) ? '0 : wrap_c[PW-1:0];
                  end else begin
                     state <= IDLE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end
               end
               default: begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_sample_player.sv
// Directed self-checking bench for sample_player (LENGTH=16, DIV=4, FRAC=8).
module tb_sample_player;

   localparam int unsigned LEN = 16;
   localparam int unsigned W   = 20;
   localparam int unsigned AW  = 4;
   localparam int unsigned DV  = 4;
   localparam int unsigned FR  = 8;

   logic                clk = 1'b0;
   logic                rst, start, stop, loop;
   logic [AW+FR-1:0]    step;
   logic [7:0]          volume;
   logic [AW-1:0]       rom_addr;
   logic signed [W-1:0] rom_data;
   logic signed [W-1:0] sample;
   logic                sample_valid, busy, done;

   logic signed [W-1:0] rom [LEN];

   int ncmp  = 0;
   int nfail = 0;

   logic signed [W-1:0] v_smp;
   logic                v_done;
   logic [AW-1:0]       v_addr;
   int                  v_wait;

   int exp2 [11] = '{0, 1, 3, 4, 6, 7, 9, 10, 12, 13, 15};
   int exp3 [8]  = '{0, 3, 6, 9, 12, 15, 2, 5};

   always #5 clk = ~clk;

   // Registered ROM model, one cycle latency
   always @(posedge clk) rom_data <= rom[rom_addr];

   sample_player #(
      .LENGTH (LEN),
      .WIDTH  (W),
      .ADDR   (AW),
      .DIV    (DV),
      .FRAC   (FR)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .stop         (stop),
      .loop         (loop),
      .step         (step),
      .volume       (volume),
      .rom_addr     (rom_addr),
      .rom_data     (rom_data),
      .sample       (sample),
      .sample_valid (sample_valid),
      .busy         (busy),
      .done         (done)
   );

   task automatic chk(input string tag, input logic signed [31:0] obs,
                      input logic signed [31:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Wait for the next sample_valid; v_addr is rom_addr in the cycle before it
   task automatic wait_valid(input string tag);
      logic          got;
      logic [AW-1:0] prev;
      got    = 1'b0;
      v_wait = 0;
      while (!got && v_wait < 40) begin
         prev = rom_addr;
         @(negedge clk);
         v_wait++;
         if (sample_valid) begin
            got    = 1'b1;
            v_smp  = sample;
            v_done = done;
            v_addr = prev;
         end
      end
      if (!got) chk({tag, " timeout"}, 32'(got), 1);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; start = 1'b0; stop = 1'b0; loop = 1'b0;
      step = '0; volume = 8'd255;
      for (int i = 0; i < int'(LEN); i++) rom[i] = W'(i);

      repeat (3) @(negedge clk);
      chk("rst sample", sample, 0);
      chk("rst valid", 32'(sample_valid), 0);
      chk("rst busy", 32'(busy), 0);
      chk("rst done", 32'(done), 0);
      chk("rst addr", 32'(rom_addr), 0);
      rst = 1'b0;

      // Ramp, unit step, no loop
      wait_valid("idle tick");
      chk("idle tick sample", v_smp, 0);
      chk("idle tick busy", 32'(busy), 0);
      step = 12'h100;
      pulse_start();
      chk("ramp busy", 32'(busy), 1);
      for (int i = 0; i < 16; i++) begin
         wait_valid("ramp");
         chk($sformatf("ramp addr %0d", i), 32'(v_addr), i);
         chk($sformatf("ramp smp %0d", i), v_smp, (i * 255) / 256);
         chk($sformatf("ramp done %0d", i), 32'(v_done), (i == 15) ? 1 : 0);
         if (i > 0) chk($sformatf("ramp period %0d", i), v_wait, DV);
      end
      @(negedge clk);
      chk("ramp busy after done", 32'(busy), 0);
      wait_valid("ramp idle");
      chk("ramp idle smp", v_smp, 0);
      chk("ramp idle done", 32'(v_done), 0);

      // Fractional step 1.5
      step = 12'h180;
      pulse_start();
      for (int i = 0; i < 11; i++) begin
         wait_valid("frac");
         chk($sformatf("frac addr %0d", i), 32'(v_addr), exp2[i]);
         chk($sformatf("frac done %0d", i), 32'(v_done), (i == 10) ? 1 : 0);
      end

      // Looping step 3
      loop = 1'b1;
      step = 12'h300;
      pulse_start();
      for (int i = 0; i < 8; i++) begin
         wait_valid("loop");
         chk($sformatf("loop addr %0d", i), 32'(v_addr), exp3[i]);
         chk($sformatf("loop done %0d", i), 32'(v_done), 0);
         chk($sformatf("loop busy %0d", i), 32'(busy), 1);
      end

      // Simultaneous stop and start mid-play
      start = 1'b1; stop = 1'b1;
      @(negedge clk);
      start = 1'b0; stop = 1'b0;
      chk("stop busy", 32'(busy), 0);
      wait_valid("stop");
      chk("stop smp", v_smp, 0);
      chk("stop done", 32'(v_done), 0);

      // Most negative sample, half volume, step 0 repeats entry 0
      rom[0] = 20'sh80000;
      volume = 8'd128;
      loop = 1'b0;
      step = '0;
      pulse_start();
      for (int i = 0; i < 2; i++) begin
         wait_valid("neg");
         chk($sformatf("neg smp %0d", i), v_smp, -262144);
         chk($sformatf("neg addr %0d", i), 32'(v_addr), 0);
         chk($sformatf("neg done %0d", i), 32'(v_done), 0);
      end
      volume = 8'd64;
      chk("vol held smp", sample, -262144);
      wait_valid("vol");
      chk("vol smp", v_smp, -131072);
      chk("vol period", v_wait, DV);

      // Reset during FETCH (tick at V+2, FETCH at V+3)
      repeat (3) @(negedge clk);
      chk("pre-rst busy", 32'(busy), 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mid-rst sample", sample, 0);
      chk("mid-rst valid", 32'(sample_valid), 0);
      chk("mid-rst busy", 32'(busy), 0);
      chk("mid-rst done", 32'(done), 0);
      chk("mid-rst addr", 32'(rom_addr), 0);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk($sformatf("post-rst valid %0d", i), 32'(sample_valid), 0);
      end
      wait_valid("post-rst first");
      chk("post-rst first smp", v_smp, 0);
      wait_valid("post-rst second");
      chk("post-rst period", v_wait, DV);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule
